// File: rtl/evm_pkg.sv
// Shared constants and FSM encoding for the EVM result-frame transmitter.
// The frame is a fixed header, four tallies and an 8-bit additive checksum.
package evm_pkg;

  localparam logic [7:0] FRAME_HEADER  = 8'hA5;
  localparam int         FRAME_BYTES   = 6;
  localparam int         BITS_PER_BYTE = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_e;

  // Carries are discarded: the receiver recomputes the same mod-256 sum.
  function automatic logic [7:0] frame_checksum(input logic [3:0][7:0] tally);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 4; i++) sum = sum + tally[i];
    return sum;
  endfunction

endpackage

// File: rtl/evm_uart_byte_tx.sv
// Single-byte UART 8N1 serializer. A load presented in the last cycle of the
// stop bit is taken on that same edge, so consecutive bytes have no idle gap.
module evm_uart_byte_tx
  import evm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LAST_CLK  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_DATA = 3'(BITS_PER_BYTE - 3);

  tx_state_e   state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;
  logic        accept;

  assign bit_end = (clk_cnt == LAST_CLK);
  assign busy    = (state != IDLE);
  assign done    = (state == STOP_BIT) && bit_end;
  assign accept  = load && ((state == IDLE) || done);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (accept) begin
      state   <= START_BIT;
      tx      <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
    end else begin
      case (state)
        IDLE: tx <= 1'b1;
        START_BIT: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= DATA_BITS;
            tx      <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_DATA) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vote_result_tx.sv
// Snapshots the four candidate tallies on start and sends them as a 6-byte
// frame (header, tallies, checksum) over a UART 8N1 line.
module vote_result_tx
  import evm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cand1_votes,
  input  logic [7:0] cand2_votes,
  input  logic [7:0] cand3_votes,
  input  logic [7:0] cand4_votes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  logic [3:0][7:0] snap;
  logic [2:0]      byte_idx;
  logic            byte_busy;
  logic            byte_done;
  logic            accept;
  logic            next_byte;
  logic            last_byte;
  logic            load;
  logic [7:0]      load_data;

  assign accept    = start && !busy && !byte_busy;
  assign next_byte = busy && byte_done && (byte_idx != LAST_IDX);
  assign last_byte = busy && byte_done && (byte_idx == LAST_IDX);
  assign load      = accept || next_byte;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_data = FRAME_HEADER;
    if (!accept) begin
      case (byte_idx)
        3'd0:    load_data = snap[0];
        3'd1:    load_data = snap[1];
        3'd2:    load_data = snap[2];
        3'd3:    load_data = snap[3];
        3'd4:    load_data = frame_checksum(snap);
        default: load_data = FRAME_HEADER;
      endcase
    end
  end

  // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset along
  // with the control state and never exposes stale tallies.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        snap     <= {cand4_votes, cand3_votes, cand2_votes, cand1_votes};
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (next_byte) begin
        byte_idx <= byte_idx + 3'd1;
      end else if (last_byte) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  evm_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (load_data),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

endmodule

// File: tb/tb_vote_result_tx.sv
// Scoreboard bench for vote_result_tx at CLKS_PER_BIT=4: expected frame bytes
// are queued at start time and compared as the tx monitor decodes each byte.
module tb_vote_result_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] c1 = 8'h00, c2 = 8'h00, c3 = 8'h00, c4 = 8'h00;
  logic       tx, busy, done;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];
  int         done_count    = 0;
  int         busy_run      = 0;
  int         last_busy_run = 0;
  bit         mon_active    = 1'b0;
  int         mon_cnt       = 0;
  logic [7:0] mon_sh;

  vote_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cand1_votes(c1),
    .cand2_votes(c2),
    .cand3_votes(c3),
    .cand4_votes(c4),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Serial decoder: samples each bit mid-cell on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run      = 0;
    end
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        int k;
        k = mon_cnt / CPB;
        if (k >= 1 && k <= 8) mon_sh[k-1] = tx;
        else if (k == 9) begin
          mon_active = 1'b0;
          compared++;
          if (tx !== 1'b1) begin
            mismatched++;
            $display("FAIL stop_bit: got %b, need 1", tx);
          end
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_byte: got %02h, need no byte", mon_sh);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (mon_sh !== e) begin
              mismatched++;
              $display("FAIL frame_byte: got %02h, need %02h", mon_sh, e);
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s;
    s = 8'(a + b + c + d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(s);
  endtask

  task automatic set_tallies(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    c1 = a; c2 = b; c3 = c; c4 = d;
  endtask

  // Ends on the first falling edge after the accepting edge (frame cycle 1).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 1000);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_timeout: got no done in %0d cycles, need done", name, n);
    end
  endtask

  task automatic check_frame_end(input string name, input int d0, input int exp_done);
    @(negedge clk);
    compared++;
    if (last_busy_run != 60 * CPB) begin
      mismatched++;
      $display("FAIL %s_busy_len: got %0d, need %0d", name, last_busy_run, 60 * CPB);
    end
    compared++;
    if (done_count - d0 != exp_done) begin
      mismatched++;
      $display("FAIL %s_done_pulses: got %0d, need %0d", name, done_count - d0, exp_done);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_bytes_left: got %0d, need 0", name, exp_q.size());
    end
    compared++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_idle_after: got busy=%b tx=%b, need busy=0 tx=1", name, busy, tx);
    end
  endtask

  task automatic test_reset();
    int lows = 0;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: got tx=%b busy=%b done=%b, need 1/0/0", tx, busy, done);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    compared++;
    if (lows != 0) begin
      mismatched++;
      $display("FAIL idle_quiet: got %0d disturbed cycles, need 0", lows);
    end
  endtask

  task automatic test_basic();
    int d0 = done_count;
    set_tallies(8'd3, 8'd1, 8'd0, 8'd7);
    push_frame(8'd3, 8'd1, 8'd0, 8'd7);
    pulse_start();
    compared++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_first_cycle: got tx=%b busy=%b, need tx=0 busy=1", tx, busy);
    end
    wait_done("basic");
    check_frame_end("basic", d0, 1);
  endtask

  task automatic test_wrap();
    int d0 = done_count;
    set_tallies(8'hFF, 8'hFF, 8'h01, 8'h02);
    push_frame(8'hFF, 8'hFF, 8'h01, 8'h02);
    pulse_start();
    wait_done("wrap");
    check_frame_end("wrap", d0, 1);
  endtask

  task automatic test_snapshot();
    int d0 = done_count;
    set_tallies(8'd3, 8'd1, 8'd0, 8'd7);
    push_frame(8'd3, 8'd1, 8'd0, 8'd7);
    pulse_start();
    repeat (49) @(negedge clk);
    set_tallies(8'd9, 8'd9, 8'd9, 8'd9);
    wait_done("snapshot");
    check_frame_end("snapshot", d0, 1);
  endtask

  task automatic test_back_to_back();
    int d0 = done_count;
    set_tallies(8'h10, 8'h20, 8'h30, 8'h40);
    push_frame(8'h10, 8'h20, 8'h30, 8'h40);
    pulse_start();
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    set_tallies(8'h55, 8'h66, 8'h77, 8'h88);
    wait_done("b2b_first");
    start = 1'b1;
    push_frame(8'h55, 8'h66, 8'h77, 8'h88);
    @(negedge clk) start = 1'b0;
    compared++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_restart: got tx=%b busy=%b, need tx=0 busy=1", tx, busy);
    end
    compared++;
    if (last_busy_run != 60 * CPB) begin
      mismatched++;
      $display("FAIL b2b_ignored_start_len: got %0d, need %0d", last_busy_run, 60 * CPB);
    end
    wait_done("b2b_second");
    check_frame_end("b2b", d0, 2);
    repeat (100) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_no_queue: got busy=%b extra=%0d, need busy=0 extra=0", busy, exp_q.size());
    end
  endtask

  task automatic test_continuous();
    int d0 = done_count;
    set_tallies(8'd1, 8'd2, 8'd3, 8'd4);
    push_frame(8'd1, 8'd2, 8'd3, 8'd4);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    repeat (49) @(negedge clk);
    set_tallies(8'd5, 8'd6, 8'd7, 8'd8);
    push_frame(8'd5, 8'd6, 8'd7, 8'd8);
    wait_done("cont_first");
    @(negedge clk);
    start = 1'b0;
    set_tallies(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    compared++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL cont_restart: got tx=%b busy=%b, need tx=0 busy=1", tx, busy);
    end
    wait_done("cont_second");
    check_frame_end("cont", d0, 2);
  endtask

  task automatic test_reset_mid();
    int d0;
    int bad = 0;
    set_tallies(8'd3, 8'd1, 8'd0, 8'd7);
    push_frame(8'd3, 8'd1, 8'd0, 8'd7);
    pulse_start();
    repeat (99) @(negedge clk);
    reset = 1'b1;
    d0 = done_count;
    @(negedge clk) reset = 1'b0;
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_abort: got tx=%b busy=%b, need tx=1 busy=0", tx, busy);
    end
    compared++;
    if (exp_q.size() != 4) begin
      mismatched++;
      $display("FAIL reset_mid_sent: got %0d bytes pending, need 4", exp_q.size());
    end
    exp_q.delete();
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    compared++;
    if (done_count != d0 || bad != 0) begin
      mismatched++;
      $display("FAIL reset_mid_quiet: got done=%0d disturbed=%0d, need 0/0", done_count - d0, bad);
    end
    d0 = done_count;
    set_tallies(8'h11, 8'h22, 8'h33, 8'h44);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    pulse_start();
    wait_done("after_reset");
    check_frame_end("after_reset", d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, need finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_snapshot();
    test_back_to_back();
    test_continuous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vote_result_tx.md
VOTE_RESULT_TX -- requirements
Module: vote_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2 to 65535.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to transmit one result frame; level sampled each cycle.
REQ-005 cand1_votes, cand2_votes, cand3_votes, cand4_votes  input  8 each  live candidate tallies from the vote logger.
REQ-006 tx  output  1  UART 8N1 serial line; idle high.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 done  output  1  one-cycle pulse at frame completion.

Function
REQ-009 Frame SHALL be 6 bytes in order: header 0xA5, cand1, cand2, cand3, cand4, checksum.
REQ-010 Checksum SHALL be (cand1+cand2+cand3+cand4) mod 256 over the snapshot values, carries discarded.
REQ-011 Each byte SHALL be sent as start bit 0, 8 data bits LSB first, stop bit 1: 10 bits per byte, no gap between bytes.
REQ-012 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-013 start SHALL be accepted only on an edge where busy=0; start while busy=1 SHALL be ignored, with no queuing.
REQ-014 On the accepting edge: all four tallies snapshotted, busy<=1, tx<=0 (start bit of header begins next cycle), byte index<=0, bit counter<=0.
REQ-015 Tally changes after the accepting edge SHALL NOT affect the frame in progress.
REQ-016 FSM states: IDLE, START_BIT, DATA_BITS (8 bits), STOP_BIT.
REQ-017 Transition IDLE->START_BIT on accept.
REQ-018 Transition START_BIT->DATA_BITS after CLKS_PER_BIT cycles.
REQ-019 Transition DATA_BITS->STOP_BIT after 8*CLKS_PER_BIT cycles.
REQ-020 Transition STOP_BIT->START_BIT (next byte) or ->IDLE after byte index 5.
REQ-021 busy SHALL be high for exactly 60*CLKS_PER_BIT cycles per frame.
REQ-022 On the edge ending the last stop bit: busy<=0, done<=1 for one cycle, tx remains 1.
REQ-023 start high in the done cycle SHALL be accepted, so back-to-back frames have zero idle bits.
REQ-024 Holding start high continuously SHALL produce consecutive frames, each with a fresh snapshot.

Reset
REQ-025 Reset values: tx=1, busy=0, done=0, state IDLE, all counters and snapshot registers 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame: tx=1 and busy=0 from the next cycle, no done pulse.
REQ-027 Reset SHALL take priority over start on the same edge.

Structure
REQ-028 Shared package evm_pkg SHALL hold FRAME_HEADER (8'hA5), FRAME_BYTES (6), BITS_PER_BYTE (10) and the FSM state encoding.
REQ-029 One sub-module evm_uart_byte_tx SHALL serialize a single byte with load/busy/done, parameterized by CLKS_PER_BIT.
REQ-030 The top level SHALL contain the snapshot registers, checksum and byte sequencer.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset -> tx=1, busy=0, done=0; no edges on tx while idle.
REQ-032 Tallies 3,1,0,7, 1-cycle start pulse -> bytes A5,03,01,00,07,0B decoded; busy high 240 cycles; single done pulse.
REQ-033 Tallies FF,FF,01,02 -> checksum byte 0x01 (wrap check).
REQ-034 Tallies change to 09,09,09,09 at cycle 50 of a frame started with 3,1,0,7 -> frame still A5,03,01,00,07,0B.
REQ-035 start pulsed at cycle 100 of a frame -> ignored, busy drops at cycle 240; start in the done cycle -> next start bit begins on the following cycle.
REQ-036 Reset at cycle 100 -> tx=1 and busy=0 next cycle, done never asserts; a subsequent start sends a full, correct frame.
